// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, ALU selection codes,
// control FSM states, mux encodings and the registered control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_ADDI = 6'b001000;
    localparam logic [5:0] ALU_ANDI = 6'b001100;
    localparam logic [5:0] ALU_LW   = 6'b100011;
    localparam logic [5:0] ALU_SW   = 6'b101011;
    localparam logic [5:0] ALU_BEQ  = 6'b000100;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
        S_MEM_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ERROR
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [5:0] alu_sel;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       busy;
        logic       err;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        c.alu_sel = ALU_ADD;
        return c;
    endfunction

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_XOR};
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction decoder: opcode dispatch target from DECODE,
// funct legality for EXEC_R, and load/store split from MEM_ADDR.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     dispatch,
    output state_t     r_next,
    output state_t     mem_next
);

    always_comb begin
        dispatch = S_ERROR;
        case (opcode)
            OP_RTYPE:         dispatch = S_EXEC_R;
            OP_ADDI, OP_ANDI: dispatch = S_EXEC_I;
            OP_LW, OP_SW:     dispatch = S_MEM_ADDR;
            OP_BEQ:           dispatch = S_BRANCH;
            OP_J:             dispatch = S_JUMP;
            default:          dispatch = S_ERROR;
        endcase
        r_next   = funct_legal(funct) ? S_R_WB : S_ERROR;
        mem_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM. Outputs are registered from the next state so
// they line up with the state register; handshake pulses ride one cycle later.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [5:0]  alu_sel,
    output logic [1:0]  alu_src_b,
    output logic        alu_src_a,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        busy,
    output logic        err
);

    state_t             state_q, state_d;
    state_t             dispatch, r_next, mem_next;
    logic [31:0]        ir_q;
    logic [CNT_W-1:0]   cnt_q;
    ctrl_t              ctrl_q, ctrl_d;
    logic               req_st, timeout;
    logic               unused_ir;

    assign unused_ir = ^ir_q[25:6];

    mips_mc_decode u_dec (
        .opcode   (ir_q[31:26]),
        .funct    (ir_q[5:0]),
        .dispatch (dispatch),
        .r_next   (r_next),
        .mem_next (mem_next)
    );

    assign req_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // ack in the final wait cycle still wins over the timeout
    assign timeout = req_st && !mem_ack && (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ack) state_d = S_DECODE;
                        else if (timeout) state_d = S_ERROR;
            S_DECODE:   state_d = dispatch;
            S_EXEC_R:   state_d = r_next;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = mem_next;
            S_MEM_RD:   if (mem_ack) state_d = S_LW_WB;
                        else if (timeout) state_d = S_ERROR;
            S_MEM_WR:   if (mem_ack) state_d = S_FETCH;
                        else if (timeout) state_d = S_ERROR;
            S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_idle();
        ctrl_d.busy = (state_d != S_IDLE) && (state_d != S_ERROR);
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:  ctrl_d.alu_src_b = SRCB_IMM_SH;
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_RT;
                ctrl_d.alu_sel   = ir_q[5:0];
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_sel   = ir_q[31:26];
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_I_WB:    ctrl_d.reg_write = 1'b1;
            S_MEM_RD: begin
                ctrl_d.mem_req  = 1'b1;
                ctrl_d.mem_iord = 1'b1;
            end
            S_LW_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_req  = 1'b1;
                ctrl_d.mem_iord = 1'b1;
                ctrl_d.mem_we   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_RT;
                ctrl_d.alu_sel   = ALU_BEQ;
            end
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = PC_JUMP;
            end
            S_ERROR:   ctrl_d.err = 1'b1;
            default:   ;
        endcase
        if (state_q == S_FETCH && mem_ack) begin
            ctrl_d.ir_write = 1'b1;
            ctrl_d.pc_write = 1'b1;
            ctrl_d.pc_src   = PC_PLUS4;
        end
        // the beq ALU code reports zero=0 on equal operands
        if (state_q == S_BRANCH && !alu_zero) begin
            ctrl_d.pc_write = 1'b1;
            ctrl_d.pc_src   = PC_BRANCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            ctrl_q  <= ctrl_idle();
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_q == S_FETCH && mem_ack)
                ir_q <= instr;
            if (req_st && !mem_ack && state_d == state_q)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign mem_iord   = ctrl_q.mem_iord;
    assign ir_write   = ctrl_q.ir_write;
    assign pc_write   = ctrl_q.pc_write;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_sel    = ctrl_q.alu_sel;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign busy       = ctrl_q.busy;
    assign err        = ctrl_q.err;

endmodule
